// File: rtl/irq_pkg.sv
// irq_pkg: shared constants and FSM state type for the interrupt controller
package irq_pkg;
  localparam int N = 8;
  localparam int IDX_W = 3;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} irq_state_t;
endpackage

// File: rtl/prio_enc8.sv
// prio_enc8: combinational 8-to-3 priority encoder, highest set bit wins
module prio_enc8
  import irq_pkg::*;
(
  input  logic [N-1:0]     req,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);
  always_comb begin
    valid = |req;
    idx = '0;
    for (int i = 0; i < N; i++) if (req[i]) idx = IDX_W'(i);
  end
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: edge-capturing, maskable interrupt controller with req/ack/eoi handshake
module irq_ctrl
  import irq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_b,
  input  logic [N-1:0]     irq_in,
  input  logic             mask_wr,
  input  logic [N-1:0]     mask_data,
  input  logic             irq_ack,
  input  logic             irq_eoi,
  output logic             irq_req,
  output logic [IDX_W-1:0] irq_idx,
  output logic             in_service,
  output logic [N-1:0]     pend,
  output logic [N-1:0]     mask
);
  irq_state_t state, nstate;
  logic [N-1:0] prev, clr;
  logic valid;
  logic [IDX_W-1:0] idx;
  prio_enc8 u_enc (.req(pend & mask), .valid(valid), .idx(idx));
  // set is OR'd after the clear so a colliding event is never lost
  assign clr = (state == REQ && irq_ack) ? N'(1) << irq_idx : '0;
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      prev <= '0;
      pend <= '0;
      mask <= '0;
      irq_idx <= '0;
    end else begin
      prev <= irq_in;
      pend <= (pend & ~clr) | (irq_in & ~prev);
      mask <= mask_wr ? mask_data : mask;
      irq_idx <= (state == IDLE && valid) ? idx : irq_idx;
    end
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) state <= IDLE;
    else state <= nstate;
  always_comb begin
    nstate = state == IDLE    ? (valid   ? REQ     : IDLE) :
             state == REQ     ? (irq_ack ? SERVICE : REQ) :
             state == SERVICE ? (irq_eoi ? IDLE    : SERVICE) : IDLE;
  end
  always_comb begin
    irq_req = state == REQ;
    in_service = state == SERVICE;
  end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scoreboard bench for irq_ctrl
module tb_irq_ctrl;
  logic clk = 0, rst_b = 0, mask_wr = 0, irq_ack = 0, irq_eoi = 0;
  logic [7:0] irq_in = 0, mask_data = 0, pend, mask;
  logic irq_req, in_service;
  logic [2:0] irq_idx;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    string tag;
    logic [20:0] v;
  } exp_t;
  exp_t q[$];

  irq_ctrl dut (.clk(clk), .rst_b(rst_b), .irq_in(irq_in), .mask_wr(mask_wr),
    .mask_data(mask_data), .irq_ack(irq_ack), .irq_eoi(irq_eoi), .irq_req(irq_req),
    .irq_idx(irq_idx), .in_service(in_service), .pend(pend), .mask(mask));

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic r, input logic [2:0] i,
                      input logic s, input logic [7:0] p, input logic [7:0] m);
    exp_t e;
    e.tag = tag;
    e.v = {r, i, s, p, m};
    q.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    logic [20:0] obs;
    while (q.size() > 0) begin
      e = q.pop_front();
      obs = {irq_req, irq_idx, in_service, pend, mask};
      n_chk++;
      assert (obs === e.v) else begin
        n_fail++;
        $error("FAIL %s: observed req/idx/ins/pend/mask=%b/%0d/%b/%h/%h expected %b/%0d/%b/%h/%h",
          e.tag, obs[20], obs[19:17], obs[16], obs[15:8], obs[7:0],
          e.v[20], e.v[19:17], e.v[16], e.v[15:8], e.v[7:0]);
      end
    end
  endtask

  task automatic cyc(input string tag, input logic r, input logic [2:0] i,
                     input logic s, input logic [7:0] p, input logic [7:0] m);
    push(tag, r, i, s, p, m);
    @(posedge clk);
    #1;
    check();
  endtask

  initial begin
    #2;
    push("rst", 0, 0, 0, 8'h00, 8'h00); check();
    @(posedge clk); #1;
    rst_b = 1;
    mask_wr = 1; mask_data = 8'hFF;
    cyc("mask_ff", 0, 0, 0, 8'h00, 8'hFF);
    mask_wr = 0; irq_in = 8'h04;
    cyc("ev2", 0, 0, 0, 8'h04, 8'hFF);
    irq_in = 0;
    cyc("req2", 1, 2, 0, 8'h04, 8'hFF);
    irq_ack = 1; cyc("ack2", 0, 2, 1, 8'h00, 8'hFF); irq_ack = 0;
    irq_eoi = 1; cyc("eoi2", 0, 2, 0, 8'h00, 8'hFF); irq_eoi = 0;
    irq_in = 8'h62;
    cyc("ev156", 0, 2, 0, 8'h62, 8'hFF);
    irq_in = 0;
    cyc("req6", 1, 6, 0, 8'h62, 8'hFF);
    irq_ack = 1; cyc("ack6", 0, 6, 1, 8'h22, 8'hFF); irq_ack = 0;
    irq_eoi = 1; cyc("eoi6", 0, 6, 0, 8'h22, 8'hFF); irq_eoi = 0;
    cyc("req5", 1, 5, 0, 8'h22, 8'hFF);
    irq_ack = 1; cyc("ack5", 0, 5, 1, 8'h02, 8'hFF); irq_ack = 0;
    irq_eoi = 1; cyc("eoi5", 0, 5, 0, 8'h02, 8'hFF); irq_eoi = 0;
    cyc("req1", 1, 1, 0, 8'h02, 8'hFF);
    irq_ack = 1; cyc("ack1", 0, 1, 1, 8'h00, 8'hFF); irq_ack = 0;
    irq_eoi = 1; cyc("eoi1", 0, 1, 0, 8'h00, 8'hFF); irq_eoi = 0;
    mask_wr = 1; mask_data = 8'h0F;
    cyc("mask_0f", 0, 1, 0, 8'h00, 8'h0F);
    mask_wr = 0; irq_in = 8'h80;
    cyc("ev7_masked", 0, 1, 0, 8'h80, 8'h0F);
    irq_in = 0;
    cyc("stay_masked", 0, 1, 0, 8'h80, 8'h0F);
    mask_wr = 1; mask_data = 8'h80;
    cyc("mask_80_oldsel", 0, 1, 0, 8'h80, 8'h80);
    mask_wr = 0;
    cyc("req7", 1, 7, 0, 8'h80, 8'h80);
    irq_ack = 1; cyc("ack7", 0, 7, 1, 8'h00, 8'h80); irq_ack = 0;
    irq_eoi = 1; cyc("eoi7", 0, 7, 0, 8'h00, 8'h80); irq_eoi = 0;
    mask_wr = 1; mask_data = 8'hFF;
    cyc("mask_ff2", 0, 7, 0, 8'h00, 8'hFF);
    mask_wr = 0; irq_in = 8'h08;
    cyc("ev3", 0, 7, 0, 8'h08, 8'hFF);
    irq_in = 0;
    cyc("req3", 1, 3, 0, 8'h08, 8'hFF);
    irq_in = 8'h80;
    cyc("ev7_in_req", 1, 3, 0, 8'h88, 8'hFF);
    irq_in = 0; mask_wr = 1; mask_data = 8'h00;
    cyc("mask_off_in_req", 1, 3, 0, 8'h88, 8'h00);
    mask_data = 8'hFF;
    cyc("mask_on_in_req", 1, 3, 0, 8'h88, 8'hFF);
    mask_wr = 0;
    irq_ack = 1; cyc("ack3", 0, 3, 1, 8'h80, 8'hFF); irq_ack = 0;
    irq_eoi = 1; cyc("eoi3", 0, 3, 0, 8'h80, 8'hFF); irq_eoi = 0;
    cyc("req7b", 1, 7, 0, 8'h80, 8'hFF);
    irq_ack = 1; cyc("ack7b", 0, 7, 1, 8'h00, 8'hFF); irq_ack = 0;
    irq_eoi = 1; cyc("eoi7b", 0, 7, 0, 8'h00, 8'hFF); irq_eoi = 0;
    irq_in = 8'h10;
    cyc("ev4", 0, 7, 0, 8'h10, 8'hFF);
    irq_in = 0;
    cyc("req4", 1, 4, 0, 8'h10, 8'hFF);
    irq_in = 8'h10; irq_ack = 1;
    cyc("ack4_collide", 0, 4, 1, 8'h10, 8'hFF);
    irq_in = 0;
    cyc("ack_in_service", 0, 4, 1, 8'h10, 8'hFF);
    irq_ack = 0;
    irq_eoi = 1; cyc("eoi4", 0, 4, 0, 8'h10, 8'hFF); irq_eoi = 0;
    cyc("rereq4", 1, 4, 0, 8'h10, 8'hFF);
    irq_ack = 1; irq_eoi = 1;
    cyc("ack_beats_eoi", 0, 4, 1, 8'h00, 8'hFF);
    irq_ack = 0; irq_eoi = 0; irq_in = 8'h01;
    cyc("rep_edge_a", 0, 4, 1, 8'h01, 8'hFF);
    irq_in = 0;
    cyc("rep_edge_b", 0, 4, 1, 8'h01, 8'hFF);
    irq_in = 8'h01;
    cyc("rep_edge_c", 0, 4, 1, 8'h01, 8'hFF);
    irq_in = 8'h02; rst_b = 0;
    #2;
    push("rst_mid", 0, 0, 0, 8'h00, 8'h00); check();
    rst_b = 1;
    cyc("edge_at_release", 0, 0, 0, 8'h02, 8'h00);
    irq_ack = 1; irq_eoi = 1;
    cyc("idle_ack_eoi", 0, 0, 0, 8'h02, 8'h00);
    irq_ack = 0; irq_eoi = 0;
    cyc("idle_hold", 0, 0, 0, 8'h02, 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Sequential interrupt controller that sits directly upstream of the 8-to-3 priority encoder. It captures rising edges on eight request lines into a pending register and applies a per-line enable mask. The enabled pending set is fed to the encoder, and the winning index is presented to the consumer through a request/acknowledge/end-of-interrupt handshake. Lines are serviced one at a time; line 7 has the highest priority and line 0 the lowest.

## Interface
- `N`, 8: number of request lines; fixed at 8 for this revision.
- `IDX_W`, 3: index width, log2(N).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_b` input 1: asynchronous, active-low reset.
- `irq_in` input N: request lines, synchronous to `clk`; a rising edge is an event.
- `mask_wr` input 1: when 1, load `mask` from `mask_data` on this edge.
- `mask_data` input N: new mask value; bit = 1 enables that line.
- `irq_ack` input 1: consumer accepts the current request.
- `irq_eoi` input 1: consumer signals end of service.
- `irq_req` output 1: request pending towards the consumer.
- `irq_idx` output IDX_W: index of the requested or in-service line; registered.
- `in_service` output 1: a line has been acknowledged and is not yet EOI'd.
- `pend` output N: pending register.
- `mask` output N: mask register.

## Operation
- Edge detect:
  - `prev` register holds `irq_in` from the previous edge.
  - Event vector = `irq_in & ~prev`.
  - Each event sets the matching bit of `pend`.
- Mask:
  - Masked lines still latch into `pend`; they are never selected.
  - Unmasking a pending line makes it eligible on the next cycle.
- Selection: `prio_enc8` operates on `pend & mask` and returns `valid` plus `idx`. Highest set bit wins.
- FSM states:
  - IDLE: `irq_req` = 0, `in_service` = 0. If `valid`, latch `idx` into `irq_idx` and go to REQ.
  - REQ: `irq_req` = 1, `irq_idx` held. On `irq_ack`:
    - clear `pend[irq_idx]`
    - `irq_req` becomes 0, `in_service` becomes 1
    - go to SERVICE
  - SERVICE: `in_service` = 1, `irq_idx` held. On `irq_eoi`: go to IDLE.
- Handshake rules:
  - `irq_ack` is ignored outside REQ.
  - `irq_eoi` is ignored outside SERVICE.
  - In REQ, `irq_ack` has priority if both are asserted.
- A request, once raised, is not withdrawn or re-indexed:
  - a higher-priority event arriving in REQ does not change `irq_idx`;
  - a mask write that disables `irq_idx` in REQ does not drop `irq_req`.
- Boundary conditions:
  - Set/clear collision: an event on line i in the same cycle as the ack-clear of i leaves `pend[i]` = 1. Set wins; no edge is lost.
  - Repeated edges on an already-pending line collapse into one pending bit.
  - `mask_wr` together with selection in IDLE: selection uses the old mask; the new mask applies from the next cycle.
  - Reset mid-operation: every register returns to its reset value immediately; an in-flight request is lost.
  - `irq_in` high at reset release counts as an edge on the first clock edge, because `prev` resets to 0.

## Timing
- Reset values:
  - `pend` = 0, `mask` = 0 (all lines disabled), `prev` = 0
  - state = IDLE, `irq_req` = 0, `irq_idx` = 0, `in_service` = 0
- Event-to-request latency:
  - `irq_in[i]` first sampled high at edge k sets `pend[i]` after k.
  - If line i is enabled and the state is IDLE, `irq_req` = 1 and `irq_idx` = i after edge k+1.
- Ack: `irq_ack` sampled at edge m in REQ. After m: `irq_req` = 0, `pend` bit cleared, `in_service` = 1.
- EOI: `irq_eoi` sampled at edge n in SERVICE. After n: IDLE. If anything else is enabled and pending, `irq_req` = 1 after n+1.
- Minimum per-interrupt cycle: 3 edges (IDLE→REQ, ack, eoi).
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package `irq_pkg`: constants `N`, `IDX_W`; enum `irq_state_t` {IDLE, REQ, SERVICE}, 2-bit encoding.
- Sub-module `prio_enc8`:
  - combinational 8-to-3 encoder with a `valid` output;
  - all-zero input gives `valid` = 0, `idx` = 0.
- Top level holds `prev`, `pend`, `mask`, the FSM and the `irq_idx` register.

## Test plan
- Reset with `irq_in` = 0, then `mask` ← 8'hFF. Pulse `irq_in[2]` at edge k → `pend` = 8'h04 after k; `irq_req` = 1, `irq_idx` = 2 after k+1.
- Simultaneous edges on lines 1, 5, 6 → `irq_idx` = 6. Ack → `pend` = 8'h22. EOI → `irq_idx` = 5 one cycle after IDLE. Then line 1 is serviced last.
- `mask` = 8'h0F, event on line 7 → `pend[7]` = 1, `irq_req` stays 0. Write `mask` = 8'h80 → `irq_req` = 1, `irq_idx` = 7.
- In REQ for line 3, event on line 7 → `irq_idx` stays 3; line 7 is serviced after the EOI for line 3.
- Event on line 4 in the same cycle as the ack of line 4 → `pend[4]` = 1 afterwards; line 4 is re-requested after EOI.
- Assert `rst_b` = 0 in SERVICE → all outputs zero immediately. `irq_ack`/`irq_eoi` pulses in IDLE → no state change.
